// File: rtl/flit_word_unpacker.sv
// Flit-to-word unpacker: buffers NoC flits in a small FIFO and streams each
// one out as FLIT_WIDTH/WORD_WIDTH words, least-significant word first.
// Flits arriving while the buffer is full (and nothing pops) are dropped and
// counted.
module flit_word_unpacker #(
    parameter int FLIT_WIDTH = 128,
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [FLIT_WIDTH-1:0]       flit_rx,
    input  logic                        flit_rx_vld,
    output logic [WORD_WIDTH-1:0]       data_out,
    output logic                        data_out_vld,
    input  logic                        data_out_rdy,
    output logic                        data_out_last,
    input  logic                        clear_overflow,
    output logic                        overflow,
    output logic [7:0]                  drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int N  = FLIT_WIDTH / WORD_WIDTH;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] IDX_LAST   = IW'(N - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(FIFO_DEPTH);

    // Flit storage; pointers carry one extra bit so full and empty differ.
    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr_reg;
    logic [AW:0]           rd_ptr_reg;
    logic [IW-1:0]         idx_reg;
    logic [IW-1:0]         idx_next;
    logic                  overflow_reg;
    logic                  overflow_next;
    logic [7:0]            drop_cnt_reg;
    logic [7:0]            drop_cnt_next;

    logic [AW:0]           level;
    logic                  full;
    logic                  word_xfer;
    logic                  pop;
    logic                  push;
    logic                  drop;
    logic [FLIT_WIDTH-1:0] head;
    logic [WORD_WIDTH-1:0] head_words [N];

    assign level = wr_ptr_reg - rd_ptr_reg;
    assign full  = (level == LEVEL_FULL);
    assign head  = mem[rd_ptr_reg[AW-1:0]];

    // Split the head flit into its word slices, word 0 in the low bits.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_word_split
            assign head_words[gi] = head[gi*WORD_WIDTH +: WORD_WIDTH];
        end
    endgenerate

    assign data_out_vld  = (level != '0);
    assign data_out      = head_words[idx_reg];
    assign data_out_last = data_out_vld && (idx_reg == IDX_LAST);

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign word_xfer = data_out_vld && data_out_rdy;
    assign pop       = word_xfer && (idx_reg == IDX_LAST);
    assign push      = flit_rx_vld && (!full || pop);
    assign drop      = flit_rx_vld && full && !pop;

    assign fifo_level = level;
    assign overflow   = overflow_reg;
    assign drop_cnt   = drop_cnt_reg;

    // Word index and drop-status next-state; a clear coinciding with a drop
    // leaves exactly that one drop recorded.
    always_comb begin
        idx_next      = idx_reg;
        overflow_next = overflow_reg;
        drop_cnt_next = drop_cnt_reg;
        if (pop) begin
            idx_next = '0;
        end else if (word_xfer) begin
            idx_next = idx_reg + 1'b1;
        end
        if (clear_overflow) begin
            overflow_next = drop;
            drop_cnt_next = drop ? 8'd1 : 8'd0;
        end else if (drop) begin
            overflow_next = 1'b1;
            if (drop_cnt_reg != 8'hFF) begin
                drop_cnt_next = drop_cnt_reg + 8'd1;
            end
        end
    end

    // Flit payload write; storage needs no reset since pointers gate validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= flit_rx;
        end
    end

    // Pointer, word index and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
            drop_cnt_reg <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            idx_reg      <= idx_next;
            overflow_reg <= overflow_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

endmodule

// File: tb/tb_flit_word_unpacker.sv
// Self-checking bench for flit_word_unpacker: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_flit_word_unpacker;

    localparam int FW    = 128;
    localparam int WW    = 32;
    localparam int DEPTH = 4;
    localparam int N     = FW / WW;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_rx;
    logic          flit_rx_vld;
    logic [WW-1:0] data_out;
    logic          data_out_vld;
    logic          data_out_rdy;
    logic          data_out_last;
    logic          clear_overflow;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic [LW-1:0] fifo_level;

    flit_word_unpacker #(
        .FLIT_WIDTH(FW),
        .WORD_WIDTH(WW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flit_rx        (flit_rx),
        .flit_rx_vld    (flit_rx_vld),
        .data_out       (data_out),
        .data_out_vld   (data_out_vld),
        .data_out_rdy   (data_out_rdy),
        .data_out_last  (data_out_last),
        .clear_overflow (clear_overflow),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of whole flits plus the word position in the head.
    logic [FW-1:0] mq[$];
    int            m_pos;
    bit            m_ovf;
    int            m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pos = 0;
        m_ovf = 1'b0;
        m_cnt = 0;
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [FW-1:0] f;
        for (int i = 0; i < N; i++) begin
            f = {f[FW-WW-1:0], WW'($urandom)};
        end
        return f;
    endfunction

    task automatic check_outputs(input string ph);
        bit            v;
        logic [FW-1:0] h;
        v = (mq.size() != 0);
        check({ph, ":vld"},   FW'(data_out_vld),  FW'(v));
        check({ph, ":last"},  FW'(data_out_last), FW'(v && (m_pos == N - 1)));
        check({ph, ":level"}, FW'(fifo_level),    FW'(mq.size()));
        check({ph, ":ovf"},   FW'(overflow),      FW'(m_ovf));
        check({ph, ":cnt"},   FW'(drop_cnt),      FW'(m_cnt));
        if (v) begin
            h = mq[0] >> (m_pos * WW);
            check({ph, ":data"}, FW'(data_out), FW'(h[WW-1:0]));
        end
    endtask

    // One clock: advance the model with the inputs seen at the rising edge,
    // then compare at the falling edge.
    task automatic cycle(input string ph);
        bit v, xfer, popping, full, accept, drop;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            v       = (mq.size() != 0);
            xfer    = v && data_out_rdy;
            popping = xfer && (m_pos == N - 1);
            full    = (mq.size() == DEPTH);
            accept  = flit_rx_vld && (!full || popping);
            drop    = flit_rx_vld && !accept;
            if (xfer) begin
                if (popping) begin
                    void'(mq.pop_front());
                    m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (accept) mq.push_back(flit_rx);
            if (clear_overflow) begin
                m_ovf = drop;
                m_cnt = drop ? 1 : 0;
            end else if (drop) begin
                m_ovf = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
        check_outputs(ph);
    endtask

    task automatic drain(input string ph);
        flit_rx_vld    = 1'b0;
        clear_overflow = 1'b0;
        data_out_rdy   = 1'b1;
        for (int i = 0; i < 64 && mq.size() != 0; i++) cycle(ph);
        check({ph, ":drained"}, FW'(fifo_level), FW'(0));
    endtask

    logic [WW-1:0] t1_words [N];
    logic [FW-1:0] f2;

    initial begin
        t1_words[0] = 32'h11111111;
        t1_words[1] = 32'h22222222;
        t1_words[2] = 32'h33333333;
        t1_words[3] = 32'h44444444;
        model_reset();

        // Reset with a flit offered: it must be ignored.
        rst = 1'b1; flit_rx = rand_flit(); flit_rx_vld = 1'b1;
        data_out_rdy = 1'b1; clear_overflow = 1'b0;
        #1;
        check_outputs("reset0");
        cycle("reset");
        cycle("reset");

        // Single flit, rdy held high; first flit accepted right after release.
        rst = 1'b0;
        flit_rx = 128'h44444444_33333333_22222222_11111111;
        flit_rx_vld = 1'b1;
        cycle("single_push");
        flit_rx_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
            check($sformatf("single_w%0d", i), FW'(data_out), FW'(t1_words[i]));
            check($sformatf("single_last%0d", i), FW'(data_out_last), FW'(i == N - 1));
            cycle("single");
        end
        check("single_empty", FW'(data_out_vld), FW'(0));

        // Backpressure: rdy pattern 1,0,0 repeating.
        for (int i = 0; i < 2; i++) begin
            flit_rx = rand_flit(); flit_rx_vld = 1'b1; data_out_rdy = 1'b0;
            cycle("bp_push");
        end
        flit_rx_vld = 1'b0;
        for (int i = 0; i < 30; i++) begin
            data_out_rdy = (i % 3 == 0);
            cycle("bp");
        end
        drain("bp");

        // Overflow: six flits back to back with rdy low.
        data_out_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            flit_rx = rand_flit(); flit_rx_vld = 1'b1;
            cycle("ovf_push");
        end
        flit_rx_vld = 1'b0;
        cycle("ovf_idle");
        check("ovf_level", FW'(fifo_level), FW'(4));
        check("ovf_flag",  FW'(overflow),   FW'(1));
        check("ovf_cnt",   FW'(drop_cnt),   FW'(2));

        // Full plus pop: push lands on the head's last-word transfer.
        data_out_rdy = 1'b1;
        for (int i = 0; i < N - 1; i++) cycle("fullpop_pre");
        flit_rx = rand_flit(); flit_rx_vld = 1'b1;
        cycle("fullpop");
        flit_rx_vld = 1'b0;
        check("fullpop_level", FW'(fifo_level), FW'(4));
        check("fullpop_cnt",   FW'(drop_cnt),   FW'(2));
        drain("fullpop");

        // Clear colliding with a drop once drop_cnt has reached 7.
        data_out_rdy = 1'b0;
        for (int i = 0; i < DEPTH + 5; i++) begin
            flit_rx = rand_flit(); flit_rx_vld = 1'b1;
            cycle("clr_fill");
        end
        check("clr_pre_cnt", FW'(drop_cnt), FW'(7));
        clear_overflow = 1'b1;
        cycle("clr_collide");
        flit_rx_vld = 1'b0; clear_overflow = 1'b0;
        check("clr_collide_ovf", FW'(overflow), FW'(1));
        check("clr_collide_cnt", FW'(drop_cnt), FW'(1));
        clear_overflow = 1'b1;
        cycle("clr_plain");
        clear_overflow = 1'b0;
        check("clr_plain_ovf", FW'(overflow), FW'(0));
        check("clr_plain_cnt", FW'(drop_cnt), FW'(0));
        drain("clr");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            flit_rx        = rand_flit();
            flit_rx_vld    = ($urandom_range(0, 99) < 30);
            data_out_rdy   = ($urandom_range(0, 99) < 70);
            clear_overflow = ($urandom_range(0, 19) == 0);
            cycle("rand");
        end
        drain("rand");

        // Reset asserted after two words of a flit.
        flit_rx = rand_flit(); flit_rx_vld = 1'b1; data_out_rdy = 1'b0;
        cycle("rst_push");
        flit_rx_vld = 1'b0; data_out_rdy = 1'b1;
        cycle("rst_w0");
        cycle("rst_w1");
        data_out_rdy = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_async_vld",   FW'(data_out_vld),  FW'(0));
        check("rst_async_last",  FW'(data_out_last), FW'(0));
        check("rst_async_level", FW'(fifo_level),    FW'(0));
        check("rst_async_ovf",   FW'(overflow),      FW'(0));
        check("rst_async_cnt",   FW'(drop_cnt),      FW'(0));
        cycle("rst_hold");
        rst = 1'b0;
        f2 = rand_flit(); flit_rx = f2; flit_rx_vld = 1'b1; data_out_rdy = 1'b1;
        cycle("rst_next_push");
        flit_rx_vld = 1'b0;
        check("rst_next_w0", FW'(data_out), FW'(f2[WW-1:0]));
        drain("rst_next");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flit_word_unpacker.md
FLIT_WORD_UNPACKER -- requirements
Module: flit_word_unpacker

Interface
REQ-001 SHALL have parameter FLIT_WIDTH, default 128, meaning NoC flit width in bits.
REQ-002 SHALL have parameter WORD_WIDTH, default 32, meaning CPU NIC word width; FLIT_WIDTH SHALL be an integer multiple of WORD_WIDTH, giving N = FLIT_WIDTH/WORD_WIDTH words per flit (default 4).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning flit buffer entries; power of two, at least 2.
REQ-004 Port: clk  input  1  single clock; all state on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: flit_rx  input  FLIT_WIDTH  flit from the NoC router.
REQ-007 Port: flit_rx_vld  input  1  flit valid for one cycle; there is no ready signal (no backpressure).
REQ-008 Port: data_out  output  WORD_WIDTH  word toward the CPU NIC receive port.
REQ-009 Port: data_out_vld  output  1  data_out holds a valid word.
REQ-010 Port: data_out_rdy  input  1  CPU accepts the word.
REQ-011 Port: data_out_last  output  1  current word is the final word of its flit.
REQ-012 Port: clear_overflow  input  1  single-cycle pulse clearing the overflow status.
REQ-013 Port: overflow  output  1  sticky flag: at least one flit dropped.
REQ-014 Port: drop_cnt  output  8  count of dropped flits, saturating at 255.
REQ-015 Port: fifo_level  output  log2(FIFO_DEPTH)+1  number of flits buffered.

Function
REQ-016 A flit SHALL be written to the FIFO tail in the cycle flit_rx_vld=1 and the FIFO is not full, or is full but a head pop occurs in that same cycle.
REQ-017 If flit_rx_vld=1 while full and no pop occurs, the flit SHALL be dropped, overflow SHALL be set, and drop_cnt SHALL increment, holding at 255 once reached.
REQ-018 data_out_vld SHALL equal (fifo_level != 0); a flit written at edge k SHALL be presented at data_out after edge k, giving a 1-cycle latency.
REQ-019 data_out SHALL be head[idx*WORD_WIDTH +: WORD_WIDTH], where idx is a word-index counter in the range 0..N-1; word 0 is the least-significant slice and is sent first.
REQ-020 A word transfer SHALL occur only when data_out_vld=1 and data_out_rdy=1; each transfer increments idx.
REQ-021 A transfer at idx=N-1 SHALL pop the head flit and wrap idx to 0; data_out_last SHALL equal data_out_vld AND (idx==N-1).
REQ-022 data_out and idx SHALL remain stable while data_out_vld=1 and data_out_rdy=0; data_out_vld SHALL NOT deassert without a transfer.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged; back-to-back flits SHALL stream with no idle cycle between the last word of one flit and the first word of the next.
REQ-024 clear_overflow SHALL zero overflow and drop_cnt; if a drop occurs in the same cycle, the result SHALL be overflow=1 and drop_cnt=1.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished using an extra pointer bit or a level counter.
REQ-026 data_out_rdy asserted while data_out_vld=0 SHALL have no effect.

Reset
REQ-027 While rst=1, the block SHALL asynchronously force: FIFO empty, idx=0, data_out_vld=0, data_out_last=0, overflow=0, drop_cnt=0, fifo_level=0; data_out content is don't-care.
REQ-028 A reset asserted mid-flit SHALL discard all buffered flits and the partial word position; after release, the first word out SHALL be word 0 of the next flit received.
REQ-029 flit_rx_vld SHALL be ignored during reset; the first flit SHALL be accepted in the first cycle after rst deasserts.

Verification
REQ-030 Single flit: flit_rx=0x44444444_33333333_22222222_11111111 with rdy held 1 -> data_out 0x11111111, 0x22222222, 0x33333333, 0x44444444 on 4 consecutive cycles starting 1 cycle after the push, last=1 only on the fourth.
REQ-031 Backpressure: rdy toggles 1,0,0,1,... -> each word held stable while rdy=0; no word is lost or duplicated; fifo_level returns to 0.
REQ-032 Overflow: 6 flits pushed on consecutive cycles with rdy=0 (DEPTH 4) -> fifo_level=4, overflow=1, drop_cnt=2; the first 4 flits drain intact.
REQ-033 Full plus pop: with FIFO full, a push coincides with the 4th-word transfer -> flit accepted, fifo_level stays 4, drop_cnt unchanged.
REQ-034 Clear collision: clear_overflow pulsed in the same cycle as a drop with drop_cnt=7 -> overflow=1, drop_cnt=1; a later clear with no drop -> 0/0.
REQ-035 Reset mid-flit: rst asserted after 2 of 4 words are transferred -> outputs take reset values immediately; the next flit starts at word 0.
